// File: rtl/tiny_cpu_pkg.sv
// Shared encodings for tiny_cpu_core: opcode fields, fixed instruction words,
// FSM states and the interrupt vector layout.
package tiny_cpu_pkg;

  typedef enum logic [1:0] {FETCH, OPER, HALT} state_t;

  // Five-bit opcode field, instruction bits [7:3]
  localparam logic [4:0] OP_ADD = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_XOR = 5'b01011;
  localparam logic [4:0] OP_INC = 5'b01100;
  localparam logic [4:0] OP_NOT = 5'b01101;
  localparam logic [4:0] OP_ROR = 5'b01110;
  localparam logic [4:0] OP_ROL = 5'b01111;
  localparam logic [4:0] OP_MVI = 5'b11100;
  localparam logic [4:0] OP_LD  = 5'b11101;
  localparam logic [4:0] OP_STR = 5'b11110;
  localparam logic [4:0] OP_RND = 5'b11111;

  localparam logic [7:0] W_JNC  = 8'hC0;
  localparam logic [7:0] W_JMP  = 8'hD0;
  localparam logic [7:0] W_CALL = 8'hC2;
  localparam logic [7:0] W_RET  = 8'hD2;
  localparam logic [7:0] W_RETI = 8'hD3;
  localparam logic [7:0] W_EI   = 8'hC1;
  localparam logic [7:0] W_DI   = 8'hD1;

  localparam int VEC_BASE = 2;

  // Maximal-length Galois taps for common widths; other widths get x^n+x+1.
  function automatic logic [31:0] lfsr_taps(input int dw);
    case (dw)
      8:       return 32'h0000_00B8;
      12:      return 32'h0000_0E08;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return (32'h1 << (dw - 1)) | 32'h1;
    endcase
  endfunction

endpackage

// File: rtl/tiny_cpu_core_if.sv
// Board-side bus of tiny_cpu_core: program-load write port and VPOKE stream.
interface tiny_cpu_core_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          vp_we;
  logic [2:0]    vp_idx;
  logic [DW-1:0] vp_data;

  modport master (output prog_we, prog_addr, prog_data, input vp_we, vp_idx, vp_data);
  modport slave  (input prog_we, prog_addr, prog_data, output vp_we, vp_idx, vp_data);
endinterface

// File: rtl/cpu_ret_stack.sv
// Return-address LIFO. Overflowing pushes and underflowing pops are ignored
// and flagged on err in the same cycle so the core can halt.
module cpu_ret_stack #(
  parameter int STK_D = 8,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty,
  output logic          err
);
  localparam int SPW = $clog2(STK_D + 1);
  localparam int IW  = (STK_D > 1) ? $clog2(STK_D) : 1;

  logic [AW-1:0]  mem [2**IW];
  logic [SPW-1:0] sp;
  logic [IW-1:0]  wr_idx, rd_idx;

  assign full   = (sp == SPW'(STK_D));
  assign empty  = (sp == '0);
  assign err    = (push && full) || (pop && empty);
  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - SPW'(1));
  assign top    = mem[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                sp <= '0;
    else if (push && !full)  sp <= sp + SPW'(1);
    else if (pop && !empty)  sp <= sp - SPW'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= push_data;
  end
endmodule

// File: rtl/tiny_cpu_core.sv
// Step-driven accumulator CPU with unified RAM, return stack, vectored IRQs
// and a loader port; halts permanently on a stack fault until reset.
module tiny_cpu_core
  import tiny_cpu_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int STK_D = 8,
  parameter int NIRQ  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic [NIRQ-1:0] irq,
  input  logic [DW-1:0]   in_port,
  tiny_cpu_core_if.slave  bus,
  output logic [DW-1:0]   out_port,
  output logic            carry,
  output logic            fault,
  output logic [AW-1:0]   pc
);
  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, push_data, stk_top, target;
  logic [DW-1:0] r_q [8];
  logic [DW-1:0] r_d [8];
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] word, src, inc, lfsr_q;
  logic [DW:0]   sum;
  logic [7:0]    ins, ins_q, ins_d;
  logic [2:0]    src_sel, vp_idx_q, vp_idx_d;
  logic [DW-1:0] vp_data_q, vp_data_d;
  logic          carry_q, carry_d, ie_q, ie_d, fault_q, fault_d, vp_we_q, vp_we_d;
  logic          push, pop, str_we, irq_hit, stk_full, stk_empty, stk_err;
  int            irq_idx;

  localparam logic [DW-1:0] TAPS = DW'(lfsr_taps(DW));

  assign word    = mem[pc_q];
  assign ins     = word[7:0];
  assign target  = word[AW-1:0];
  assign src_sel = (state_q == OPER) ? ins_q[2:0] : ins[2:0];
  assign src     = (src_sel == 3'd5) ? in_port : r_q[src_sel];

  cpu_ret_stack #(.STK_D(STK_D), .AW(AW)) u_stack (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .top(stk_top), .full(stk_full), .empty(stk_empty), .err(stk_err)
  );

  always_comb begin
    irq_hit = 1'b0;
    irq_idx = 0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq[i]) begin
        irq_hit = 1'b1;
        irq_idx = i;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    r_d       = r_q;
    carry_d   = carry_q;
    ie_d      = ie_q;
    fault_d   = fault_q;
    ins_d     = ins_q;
    vp_we_d   = 1'b0;
    vp_idx_d  = vp_idx_q;
    vp_data_d = vp_data_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_q;
    str_we    = 1'b0;
    sum       = {1'b0, r_q[0]} + {1'b0, src};
    inc       = src + DW'(1);
    if (step) begin
      unique case (state_q)
        FETCH: begin
          if (ie_q && irq_hit) begin
            push = 1'b1;
            pc_d = AW'(VEC_BASE + 2 * irq_idx);
            ie_d = 1'b0;
          end else begin
            pc_d = pc_q + AW'(1);
            casez (ins[7:3])
              5'b00???: r_d[ins[5:3]] = src;
              5'b10???: begin
                vp_we_d   = 1'b1;
                vp_idx_d  = ins[5:3];
                vp_data_d = src;
              end
              OP_ADD: begin
                r_d[0]  = sum[DW-1:0];
                carry_d = sum[DW];
              end
              OP_OR:  r_d[0] = r_q[0] | src;
              OP_AND: r_d[0] = r_q[0] & src;
              OP_XOR: r_d[0] = r_q[0] ^ src;
              OP_INC: begin
                r_d[ins[2:0]] = inc;
                carry_d       = (inc == '0);
              end
              OP_NOT: r_d[ins[2:0]] = ~src;
              OP_ROR: r_d[ins[2:0]] = {src[0], src[DW-1:1]};
              OP_ROL: r_d[ins[2:0]] = {src[DW-2:0], src[DW-1]};
              OP_RND: r_d[ins[2:0]] = lfsr_q;
              OP_MVI, OP_LD, OP_STR: begin
                ins_d   = ins;
                state_d = OPER;
              end
              default: begin
                case (ins)
                  W_JNC, W_JMP, W_CALL: begin
                    ins_d   = ins;
                    state_d = OPER;
                  end
                  W_RET, W_RETI: begin
                    pop  = 1'b1;
                    pc_d = stk_top;
                    if (ins == W_RETI) ie_d = 1'b1;
                  end
                  W_EI:    ie_d = 1'b1;
                  W_DI:    ie_d = 1'b0;
                  default: ;
                endcase
              end
            endcase
          end
        end
        OPER: begin
          state_d = FETCH;
          pc_d    = pc_q + AW'(1);
          case (ins_q[7:3])
            OP_MVI: r_d[ins_q[2:0]] = word;
            OP_LD:  r_d[ins_q[2:0]] = mem[target];
            OP_STR: str_we = 1'b1;
            default: begin
              if (ins_q == W_JMP) begin
                pc_d = target;
              end else if (ins_q == W_JNC) begin
                if (!carry_q) pc_d = target;
                carry_d = 1'b0;
              end else if (ins_q == W_CALL) begin
                push      = 1'b1;
                push_data = pc_q + AW'(1);
                pc_d      = target;
              end
            end
          endcase
        end
        default: ;
      endcase
      // A rejected push/pop freezes pc and interrupt enable and parks the core.
      if (stk_err) begin
        state_d = HALT;
        fault_d = 1'b1;
        pc_d    = pc_q;
        ie_d    = ie_q;
      end
      if (state_q != HALT) r_d[5] = in_port;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q   <= FETCH;
      pc_q      <= '0;
      carry_q   <= 1'b0;
      ie_q      <= 1'b1;
      fault_q   <= 1'b0;
      ins_q     <= '0;
      vp_we_q   <= 1'b0;
      vp_idx_q  <= '0;
      vp_data_q <= '0;
      lfsr_q    <= DW'(1);
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      r_q       <= r_d;
      carry_q   <= carry_d;
      ie_q      <= ie_d;
      fault_q   <= fault_d;
      ins_q     <= ins_d;
      vp_we_q   <= vp_we_d;
      vp_idx_q  <= vp_idx_d;
      vp_data_q <= vp_data_d;
      lfsr_q    <= {1'b0, lfsr_q[DW-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  // NOTE: RAM is deliberately left out of reset so a loaded program survives it.
  // The loader write comes last so it wins a same-address collision with STR.
  always_ff @(posedge clk) begin
    if (str_we)      mem[target]        <= src;
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end

  assign out_port    = r_q[6];
  assign carry       = carry_q;
  assign fault       = fault_q;
  assign pc          = pc_q;
  assign bus.vp_we   = vp_we_q;
  assign bus.vp_idx  = vp_idx_q;
  assign bus.vp_data = vp_data_q;
endmodule

// File: tb/tb_tiny_cpu_core.sv
// Directed bench for tiny_cpu_core: table of single-instruction ALU vectors
// plus hand-written sequences for branches, calls, interrupts and faults.
module tb_tiny_cpu_core;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step = 1'b0;
  logic [2:0] irq = '0;
  logic [7:0] in_port = '0;
  logic [7:0] out_port;
  logic       carry, fault;
  logic [7:0] pc;
  int         checks = 0;
  int         errors = 0;

  tiny_cpu_core_if #(.DW(8), .AW(8)) bus ();

  tiny_cpu_core #(.DW(8), .AW(8), .STK_D(2), .NIRQ(3)) dut (
    .clk(clk), .rst(rst), .step(step), .irq(irq), .in_port(in_port),
    .bus(bus), .out_port(out_port), .carry(carry), .fault(fault), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] ins;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_c;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic restart();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
  endtask

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;

    vecs[0]  = '{"add_carry",  8'h45, 8'd200, 8'd100, 8'h2C, 1'b1};
    vecs[1]  = '{"add_plain",  8'h45, 8'h10,  8'h20,  8'h30, 1'b0};
    vecs[2]  = '{"or",         8'h4D, 8'hF0,  8'h0F,  8'hFF, 1'b0};
    vecs[3]  = '{"and",        8'h55, 8'hF0,  8'h3C,  8'h30, 1'b0};
    vecs[4]  = '{"xor",        8'h5D, 8'hFF,  8'h0F,  8'hF0, 1'b0};
    vecs[5]  = '{"inc_wrap",   8'h60, 8'hFF,  8'h00,  8'h00, 1'b1};
    vecs[6]  = '{"inc_plain",  8'h60, 8'h41,  8'h00,  8'h42, 1'b0};
    vecs[7]  = '{"not",        8'h68, 8'h5A,  8'h00,  8'hA5, 1'b0};
    vecs[8]  = '{"ror",        8'h70, 8'h01,  8'h00,  8'h80, 1'b0};
    vecs[9]  = '{"rol",        8'h78, 8'h81,  8'h00,  8'h03, 1'b0};
    vecs[10] = '{"mov_in",     8'h05, 8'h12,  8'h77,  8'h77, 1'b0};
    vecs[11] = '{"nop",        8'hC4, 8'h12,  8'h00,  8'h12, 1'b0};

    // Reset state
    restart();
    check("reset_pc", pc, 8'h00);
    check("reset_out", out_port, 8'h00);
    check("reset_carry", carry, 1'b0);
    check("reset_fault", fault, 1'b0);
    check("reset_vp_we", bus.vp_we, 1'b0);

    // ALU vectors: MVI r0,a ; <ins> ; MOV r6,r0 with in_port=b feeding r5
    for (int v = 0; v < 12; v++) begin
      load(8'h00, 8'hE0);
      load(8'h01, vecs[v].a);
      load(8'h02, vecs[v].ins);
      load(8'h03, 8'h30);
      in_port = vecs[v].b;
      restart();
      do_steps(4);
      check({vecs[v].name, "_out"}, out_port, vecs[v].exp_out);
      check({vecs[v].name, "_carry"}, carry, vecs[v].exp_c);
    end
    in_port = '0;

    // ADD with carry, then JNC falls through and clears carry
    load(8'h00, 8'hE1); load(8'h01, 8'd200); load(8'h02, 8'hE0); load(8'h03, 8'd100);
    load(8'h04, 8'h41); load(8'h05, 8'hC0); load(8'h06, 8'h20); load(8'h07, 8'h30);
    restart();
    do_steps(5);
    check("add_seq_carry", carry, 1'b1);
    check("add_seq_pc", pc, 8'h05);
    do_steps(2);
    check("jnc_fall_pc", pc, 8'h07);
    check("jnc_clr_carry", carry, 1'b0);
    do_steps(1);
    check("add_seq_r0", out_port, 8'd44);

    // CALL / RET
    load(8'h00, 8'hC2); load(8'h01, 8'h40); load(8'h02, 8'h00);
    load(8'h40, 8'hE6); load(8'h41, 8'h5A); load(8'h42, 8'hD2);
    restart();
    do_steps(2);
    check("call_pc", pc, 8'h40);
    do_steps(3);
    check("ret_out", out_port, 8'h5A);
    check("ret_pc", pc, 8'h02);

    // Interrupt priority, ie masking and RETI
    load(8'h00, 8'hD0); load(8'h01, 8'h10); load(8'h10, 8'h00);
    load(8'h04, 8'hD3); load(8'h06, 8'hD3);
    restart();
    do_steps(2);
    check("jmp_pc", pc, 8'h10);
    irq = 3'b110;
    do_steps(1);
    check("irq1_vector", pc, 8'h04);
    do_steps(1);
    check("reti_masked_pc", pc, 8'h10);
    do_steps(1);
    check("irq_reenable_pc", pc, 8'h04);
    irq = 3'b000;
    do_steps(1);
    check("reti_pc", pc, 8'h10);
    irq = 3'b100;
    do_steps(1);
    check("irq2_vector", pc, 8'h06);
    irq = 3'b000;
    do_steps(1);
    check("reti2_pc", pc, 8'h10);
    check("irq_no_fault", fault, 1'b0);

    // Stack overflow with depth 2
    load(8'h00, 8'hC2); load(8'h01, 8'h10);
    load(8'h10, 8'hC2); load(8'h11, 8'h20);
    load(8'h20, 8'hC2); load(8'h21, 8'h30);
    restart();
    do_steps(4);
    check("nest2_pc", pc, 8'h20);
    check("nest2_fault", fault, 1'b0);
    do_steps(2);
    check("ovf_fault", fault, 1'b1);
    check("ovf_pc", pc, 8'h21);
    in_port = 8'h3C;
    irq = 3'b001;
    do_steps(3);
    check("halt_pc", pc, 8'h21);
    check("halt_fault", fault, 1'b1);
    check("halt_out", out_port, 8'h00);
    irq = 3'b000;
    in_port = '0;

    // Underflow, then asynchronous reset mid-cycle
    load(8'h00, 8'hE6); load(8'h01, 8'hAA); load(8'h02, 8'hD2);
    restart();
    do_steps(2);
    check("pre_unf_out", out_port, 8'hAA);
    do_steps(1);
    check("unf_fault", fault, 1'b1);
    check("unf_pc", pc, 8'h02);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_fault", fault, 1'b0);
    check("arst_out", out_port, 8'h00);
    check("arst_pc", pc, 8'h00);
    check("arst_carry", carry, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // VPOKE r3 -> row 5
    load(8'h00, 8'hE3); load(8'h01, 8'h81); load(8'h02, 8'hAB);
    restart();
    do_steps(3);
    check("vp_we_pulse", bus.vp_we, 1'b1);
    check("vp_idx", bus.vp_idx, 3'd5);
    check("vp_data", bus.vp_data, 8'h81);
    @(negedge clk);
    check("vp_we_drop", bus.vp_we, 1'b0);

    // Loader write beats STR on the same address; plain STR/LD round trip
    load(8'h00, 8'hE3); load(8'h01, 8'h81);
    load(8'h02, 8'hF3); load(8'h03, 8'h80);
    load(8'h04, 8'hF3); load(8'h05, 8'h81);
    load(8'h06, 8'hEA); load(8'h07, 8'h80); load(8'h08, 8'h32);
    load(8'h09, 8'hEA); load(8'h0A, 8'h81); load(8'h0B, 8'h32);
    load(8'h80, 8'h00); load(8'h81, 8'h00);
    restart();
    do_steps(3);
    @(negedge clk);
    step = 1'b1;
    bus.prog_we = 1'b1;
    bus.prog_addr = 8'h80;
    bus.prog_data = 8'h3C;
    @(negedge clk);
    step = 1'b0;
    bus.prog_we = 1'b0;
    do_steps(5);
    check("prog_wins", out_port, 8'h3C);
    do_steps(3);
    check("str_ld", out_port, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
